// File: rtl/duck_pkg.sv
// Shared types and sprite-sheet layout constants for the duck flight controller.
// Each colour owns a 20-frame block; the offsets below index into that block.
package duck_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_FLY,
    ST_HIT,
    ST_FALL,
    ST_ESCAPE,
    ST_DONE
  } duck_state_e;

  // Bit 1 set means the duck heads east; swapping heading only flips that bit.
  typedef enum logic [1:0] {
    DIR_NW = 2'd0,
    DIR_W  = 2'd1,
    DIR_NE = 2'd2,
    DIR_E  = 2'd3
  } duck_dir_e;

  typedef enum logic [1:0] {
    COL_BLACK = 2'd0,
    COL_RED   = 2'd1,
    COL_PINK  = 2'd2
  } duck_color_e;

  typedef enum logic [1:0] {
    MODE_FLY,
    MODE_HIT,
    MODE_FALL,
    MODE_ESCAPE
  } duck_mode_e;

  localparam int FRAME_COLOR_STRIDE = 20;
  localparam int FRAME_OFS_NE       = 0;
  localparam int FRAME_OFS_E        = 4;
  localparam int FRAME_OFS_NW       = 11;
  localparam int FRAME_OFS_W        = 15;
  localparam int FRAME_OFS_HIT      = 8;
  localparam int FRAME_OFS_FALL     = 9;

  function automatic duck_dir_e swap_dir(input duck_dir_e d);
    return duck_dir_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/duck_frame_lut.sv
// Maps colour, heading, animation mode and wing phase to a sprite frame index.
module duck_frame_lut
  import duck_pkg::*;
(
  input  duck_color_e color,
  input  duck_dir_e   dir,
  input  duck_mode_e  mode,
  input  logic [1:0]  phase,
  output logic [5:0]  frame
);

  int base;
  int ofs;

  always_comb begin
    base = int'(color) * FRAME_COLOR_STRIDE;
    ofs  = 0;
    case (mode)
      MODE_FLY: begin
        case (dir)
          DIR_NE:  ofs = FRAME_OFS_NE;
          DIR_E:   ofs = FRAME_OFS_E;
          DIR_NW:  ofs = FRAME_OFS_NW;
          default: ofs = FRAME_OFS_W;
        endcase
        ofs = ofs + int'(phase);
      end
      MODE_HIT:  ofs = FRAME_OFS_HIT;
      MODE_FALL: ofs = FRAME_OFS_FALL;
      // Escaping ducks climb straight up, keeping only their east/west facing.
      default:   ofs = (dir[1] ? FRAME_OFS_NE : FRAME_OFS_NW) + int'(phase);
    endcase
    frame = 6'(base + ofs);
  end

endmodule

// File: rtl/duck_flight_ctrl.sv
// Duck flight FSM: launch, bouncing flight, hit/fall or escape, one-tick done pulse.
// Handshake: Start is a level sampled only in IDLE; Done is a single-tick pulse with Result valid.
module duck_flight_ctrl
  import duck_pkg::*;
#(
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 607,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 300,
  parameter int STEP_LG_X = 8,
  parameter int STEP_SM_X = 6,
  parameter int STEP_LG_Y = 5,
  parameter int STEP_SM_Y = 1,
  parameter int FLY_TICKS = 40,
  parameter int HIT_TICKS = 5,
  parameter int FALL_STEP = 8
) (
  input  logic        ANIM_Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Shot,
  input  logic [1:0]  Color_in,
  input  logic [1:0]  Dir_in,
  input  logic [9:0]  Start_X,
  output logic [9:0]  Duck_X,
  output logic [9:0]  Duck_Y,
  output logic [5:0]  DuckFrame,
  output logic        Busy,
  output logic        Done,
  output logic        Result,
  output duck_state_e dbg_state
);

  localparam logic signed [11:0] XMIN_S = 12'(X_MIN);
  localparam logic signed [11:0] XMAX_S = 12'(X_MAX);
  localparam logic signed [11:0] YMIN_S = 12'(Y_MIN);
  localparam logic signed [11:0] YMAX_S = 12'(Y_MAX);
  localparam logic signed [11:0] LG_X_S = 12'(STEP_LG_X);
  localparam logic signed [11:0] SM_X_S = 12'(STEP_SM_X);
  localparam logic signed [11:0] LG_Y_S = 12'(STEP_LG_Y);
  localparam logic signed [11:0] SM_Y_S = 12'(STEP_SM_Y);
  localparam logic signed [11:0] FALL_S = 12'(FALL_STEP);
  localparam logic [9:0]  X_MIN10  = 10'(X_MIN);
  localparam logic [9:0]  X_MAX10  = 10'(X_MAX);
  localparam logic [9:0]  Y_MIN10  = 10'(Y_MIN);
  localparam logic [9:0]  Y_MAX10  = 10'(Y_MAX);
  localparam logic [15:0] FLY_LAST = 16'(FLY_TICKS - 1);
  localparam logic [15:0] HIT_LAST = 16'(HIT_TICKS - 1);

  duck_state_e state_q, state_d;
  duck_dir_e   dir_q, dir_d;
  duck_color_e color_q, color_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [1:0]  phase_q, phase_d;
  logic        sense_down_q, sense_down_d;
  logic [15:0] fly_cnt_q, fly_cnt_d, hit_cnt_q, hit_cnt_d;
  logic        result_q, result_d;

  logic signed [11:0] x_s, y_s, dx, dy, fx, fy, fall_y, esc_y, sx_s;
  logic [9:0]  mv_x, mv_y, start_x_clamped;
  duck_dir_e   mv_dir;
  logic [1:0]  mv_phase;
  logic        mv_sense;
  duck_mode_e  mode;
  logic [5:0]  lut_frame;

  // One flight step with 12-bit signed headroom so left/top overshoot never wraps.
  always_comb begin
    x_s = $signed({2'b00, x_q});
    y_s = $signed({2'b00, y_q});
    dx  = '0;
    dy  = '0;
    case (dir_q)
      DIR_NW:  begin dx = -SM_X_S; dy = -LG_Y_S; end
      DIR_W:   begin dx = -LG_X_S; dy = -SM_Y_S; end
      DIR_NE:  begin dx =  SM_X_S; dy = -LG_Y_S; end
      default: begin dx =  LG_X_S; dy = -SM_Y_S; end
    endcase
    if (sense_down_q) dy = -dy;
    fx = x_s + dx;
    fy = y_s + dy;

    mv_x     = fx[9:0];
    mv_dir   = dir_q;
    mv_phase = phase_q + 2'd1;
    if (fx < XMIN_S) begin
      mv_x     = X_MIN10;
      mv_dir   = swap_dir(dir_q);
      mv_phase = 2'd0;
    end else if (fx > XMAX_S) begin
      mv_x     = X_MAX10;
      mv_dir   = swap_dir(dir_q);
      mv_phase = 2'd0;
    end

    mv_y     = fy[9:0];
    mv_sense = sense_down_q;
    if (fy < YMIN_S) begin
      mv_y     = Y_MIN10;
      mv_sense = 1'b1;
    end else if (fy > YMAX_S) begin
      mv_y     = Y_MAX10;
      mv_sense = 1'b0;
    end

    fall_y = y_s + FALL_S;
    esc_y  = y_s - LG_Y_S;
    sx_s   = $signed({2'b00, Start_X});
    if (sx_s < XMIN_S)      start_x_clamped = X_MIN10;
    else if (sx_s > XMAX_S) start_x_clamped = X_MAX10;
    else                    start_x_clamped = Start_X;
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    color_d      = color_q;
    x_d          = x_q;
    y_d          = y_q;
    phase_d      = phase_q;
    sense_down_d = sense_down_q;
    fly_cnt_d    = fly_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    result_d     = result_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          color_d      = duck_color_e'((Color_in == 2'd3) ? 2'd0 : Color_in);
          dir_d        = duck_dir_e'(Dir_in);
          x_d          = start_x_clamped;
          y_d          = Y_MAX10;
          phase_d      = 2'd0;
          sense_down_d = 1'b0;
          fly_cnt_d    = '0;
          hit_cnt_d    = '0;
          result_d     = 1'b0;
          state_d      = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        x_d          = mv_x;
        y_d          = mv_y;
        dir_d        = mv_dir;
        phase_d      = mv_phase;
        sense_down_d = mv_sense;
        state_d      = ST_FLY;
      end
      ST_FLY: begin
        if (Shot) begin
          hit_cnt_d = '0;
          state_d   = ST_HIT;
        end else if (fly_cnt_q == FLY_LAST) begin
          state_d = ST_ESCAPE;
        end else begin
          x_d          = mv_x;
          y_d          = mv_y;
          dir_d        = mv_dir;
          phase_d      = mv_phase;
          sense_down_d = mv_sense;
          fly_cnt_d    = fly_cnt_q + 16'd1;
        end
      end
      ST_HIT: begin
        if (hit_cnt_q == HIT_LAST) state_d = ST_FALL;
        else                       hit_cnt_d = hit_cnt_q + 16'd1;
      end
      ST_FALL: begin
        if (fall_y >= YMAX_S) begin
          y_d      = Y_MAX10;
          result_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          y_d = fall_y[9:0];
        end
      end
      ST_ESCAPE: begin
        phase_d = phase_q + 2'd1;
        if (esc_y <= YMIN_S) begin
          y_d      = Y_MIN10;
          result_d = 1'b0;
          state_d  = ST_DONE;
        end else begin
          y_d = esc_y[9:0];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ANIM_Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_NW;
      color_q      <= COL_BLACK;
      x_q          <= '0;
      y_q          <= Y_MAX10;
      phase_q      <= '0;
      sense_down_q <= 1'b0;
      fly_cnt_q    <= '0;
      hit_cnt_q    <= '0;
      result_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      color_q      <= color_d;
      x_q          <= x_d;
      y_q          <= y_d;
      phase_q      <= phase_d;
      sense_down_q <= sense_down_d;
      fly_cnt_q    <= fly_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      result_q     <= result_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_HIT:    mode = MODE_HIT;
      ST_FALL:   mode = MODE_FALL;
      ST_ESCAPE: mode = MODE_ESCAPE;
      ST_DONE:   mode = result_q ? MODE_FALL : MODE_ESCAPE;
      default:   mode = MODE_FLY;
    endcase
  end

  duck_frame_lut u_frame_lut (
    .color (color_q),
    .dir   (dir_q),
    .mode  (mode),
    .phase (phase_q),
    .frame (lut_frame)
  );

  assign Duck_X    = x_q;
  assign Duck_Y    = y_q;
  assign DuckFrame = (state_q == ST_IDLE) ? 6'd0 : lut_frame;
  assign Busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign Done      = (state_q == ST_DONE);
  assign Result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_duck_flight_ctrl.sv
// Directed bench for duck_flight_ctrl with hand-computed positions, frames and durations.
module tb_duck_flight_ctrl;
  import duck_pkg::*;

  logic        ANIM_Clk;
  logic        Reset;
  logic        Start;
  logic        Shot;
  logic [1:0]  Color_in;
  logic [1:0]  Dir_in;
  logic [9:0]  Start_X;
  logic [9:0]  Duck_X;
  logic [9:0]  Duck_Y;
  logic [5:0]  DuckFrame;
  logic        Busy;
  logic        Done;
  logic        Result;
  duck_state_e dbg_state;

  int checks   = 0;
  int failures = 0;

  duck_flight_ctrl dut (
    .ANIM_Clk  (ANIM_Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Shot      (Shot),
    .Color_in  (Color_in),
    .Dir_in    (Dir_in),
    .Start_X   (Start_X),
    .Duck_X    (Duck_X),
    .Duck_Y    (Duck_Y),
    .DuckFrame (DuckFrame),
    .Busy      (Busy),
    .Done      (Done),
    .Result    (Result),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial ANIM_Clk = 1'b0;
  always #5 ANIM_Clk = ~ANIM_Clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ANIM_Clk);
    #1;
  endtask

  task automatic start_flight(input logic [1:0] c, input logic [1:0] d, input logic [9:0] x);
    Color_in = c;
    Dir_in   = d;
    Start_X  = x;
    Start    = 1'b1;
    step();
    Start    = 1'b0;
  endtask

  int exp_x [4] = '{408, 416, 424, 432};
  int exp_y [4] = '{299, 298, 297, 296};
  int exp_f [4] = '{25, 26, 27, 24};
  int n;
  logic done_seen;

  initial begin
    Reset = 1'b1; Start = 1'b0; Shot = 1'b0;
    Color_in = '0; Dir_in = '0; Start_X = '0;
    repeat (2) @(posedge ANIM_Clk);
    #1;
    check_eq("rst_state", int'(dbg_state), int'(ST_IDLE));
    check_eq("rst_x", Duck_X, 0);
    check_eq("rst_y", Duck_Y, 300);
    check_eq("rst_frame", DuckFrame, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_done", Done, 0);
    check_eq("rst_result", Result, 0);
    Reset = 1'b0;
    step();

    // red duck heading east: launch, flight table, ignored Start, escape
    start_flight(2'd1, 2'd3, 10'd400);
    check_eq("t1_launch_state", int'(dbg_state), int'(ST_LAUNCH));
    check_eq("t1_launch_x", Duck_X, 400);
    check_eq("t1_launch_y", Duck_Y, 300);
    check_eq("t1_launch_frame", DuckFrame, 24);
    check_eq("t1_launch_busy", Busy, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t1_fly_x", Duck_X, exp_x[i]);
      check_eq("t1_fly_y", Duck_Y, exp_y[i]);
      check_eq("t1_fly_frame", DuckFrame, exp_f[i]);
    end
    Start = 1'b1; Start_X = 10'd100;
    step();
    Start = 1'b0;
    check_eq("t1_start_ign_state", int'(dbg_state), int'(ST_FLY));
    check_eq("t1_start_ign_x", Duck_X, 440);
    check_eq("t1_start_ign_y", Duck_Y, 295);
    check_eq("t1_start_ign_frame", DuckFrame, 25);
    n = 0;
    while (dbg_state != ST_ESCAPE && n < 100) begin
      step();
      n++;
    end
    check_eq("t1_fly_len", n, 36);
    check_eq("t1_esc_x", Duck_X, 495);
    check_eq("t1_esc_y", Duck_Y, 260);
    check_eq("t1_esc_frame", DuckFrame, 33);
    check_eq("t1_esc_busy", Busy, 1);
    n = 0;
    while (dbg_state != ST_DONE && n < 200) begin
      step();
      n++;
    end
    check_eq("t1_esc_len", n, 52);
    check_eq("t1_done", Done, 1);
    check_eq("t1_done_busy", Busy, 0);
    check_eq("t1_done_y", Duck_Y, 0);
    check_eq("t1_done_x", Duck_X, 495);
    check_eq("t1_result", Result, 0);
    step();
    check_eq("t1_idle_state", int'(dbg_state), int'(ST_IDLE));
    check_eq("t1_done_pulse", Done, 0);
    check_eq("t1_idle_frame", DuckFrame, 0);

    // right-wall bounce, then asynchronous reset mid-flight
    start_flight(2'd1, 2'd3, 10'd600);
    check_eq("t2_launch_x", Duck_X, 600);
    step();
    check_eq("t2_bounce_x", Duck_X, 607);
    check_eq("t2_bounce_y", Duck_Y, 299);
    check_eq("t2_bounce_frame", DuckFrame, 35);
    step();
    check_eq("t2_after_x", Duck_X, 599);
    check_eq("t2_after_frame", DuckFrame, 36);
    #2 Reset = 1'b1;
    #1;
    check_eq("t2_async_state", int'(dbg_state), int'(ST_IDLE));
    check_eq("t2_async_x", Duck_X, 0);
    check_eq("t2_async_y", Duck_Y, 300);
    step();
    Reset = 1'b0;
    step();

    // clamped launch X, Shot on the timeout tick, Reset during FALL
    start_flight(2'd2, 2'd1, 10'd1000);
    check_eq("t3_clamp_x", Duck_X, 607);
    check_eq("t3_launch_frame", DuckFrame, 55);
    step();
    check_eq("t3_fly_x", Duck_X, 599);
    check_eq("t3_fly_frame", DuckFrame, 56);
    repeat (39) step();
    check_eq("t3_tick40_state", int'(dbg_state), int'(ST_FLY));
    Shot = 1'b1;
    step();
    Shot = 1'b0;
    check_eq("t3_hit_state", int'(dbg_state), int'(ST_HIT));
    check_eq("t3_hit_x", Duck_X, 287);
    check_eq("t3_hit_y", Duck_Y, 260);
    check_eq("t3_hit_frame", DuckFrame, 48);
    n = 0;
    while (dbg_state == ST_HIT && n < 20) begin
      step();
      n++;
    end
    check_eq("t3_hit_len", n, 5);
    check_eq("t3_fall_y", Duck_Y, 260);
    check_eq("t3_fall_frame", DuckFrame, 49);
    step();
    check_eq("t3_fall_y2", Duck_Y, 268);
    #2 Reset = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      done_seen = done_seen | Done;
    end
    check_eq("t3_rst_state", int'(dbg_state), int'(ST_IDLE));
    check_eq("t3_rst_y", Duck_Y, 300);
    check_eq("t3_rst_no_done", done_seen, 0);
    check_eq("t3_rst_busy", Busy, 0);
    Reset = 1'b0;
    step();

    // black duck heading NW, Shot ignored in IDLE/LAUNCH, shot on FLY tick 3
    Shot = 1'b1;
    start_flight(2'd0, 2'd0, 10'd300);
    check_eq("t4_launch_frame", DuckFrame, 11);
    step();
    Shot = 1'b0;
    check_eq("t4_shot_ign_state", int'(dbg_state), int'(ST_FLY));
    check_eq("t4_fly1_x", Duck_X, 294);
    check_eq("t4_fly1_y", Duck_Y, 295);
    check_eq("t4_fly1_frame", DuckFrame, 12);
    step();
    check_eq("t4_fly2_frame", DuckFrame, 13);
    step();
    check_eq("t4_fly3_x", Duck_X, 282);
    check_eq("t4_fly3_y", Duck_Y, 285);
    check_eq("t4_fly3_frame", DuckFrame, 14);
    Shot = 1'b1;
    step();
    Shot = 1'b0;
    check_eq("t4_hit_state", int'(dbg_state), int'(ST_HIT));
    n = 0;
    while (dbg_state == ST_HIT && n < 20) begin
      check_eq("t4_hit_frame", DuckFrame, 8);
      check_eq("t4_hit_y", Duck_Y, 285);
      step();
      n++;
    end
    check_eq("t4_hit_len", n, 5);
    check_eq("t4_fall_frame", DuckFrame, 9);
    check_eq("t4_fall_y", Duck_Y, 285);
    step();
    check_eq("t4_fall_y2", Duck_Y, 293);
    step();
    check_eq("t4_done", Done, 1);
    check_eq("t4_done_y", Duck_Y, 300);
    check_eq("t4_done_x", Duck_X, 282);
    check_eq("t4_result", Result, 1);
    step();
    check_eq("t4_done_pulse", Done, 0);
    check_eq("t4_result_hold", Result, 1);

    // colour 3 behaves as black; Result clears at the next launch
    start_flight(2'd3, 2'd3, 10'd10);
    check_eq("t5_launch_frame", DuckFrame, 4);
    check_eq("t5_launch_x", Duck_X, 10);
    check_eq("t5_result_clr", Result, 0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/duck_flight_ctrl.md
DUCK_FLIGHT_CTRL -- requirements
Module: duck_flight_ctrl

Interface
REQ-001 SHALL have parameter X_MIN, default 0, left clamp for Duck_X.
REQ-002 SHALL have parameter X_MAX, default 607, right clamp for Duck_X.
REQ-003 SHALL have parameter Y_MIN, default 0, top clamp for Duck_Y.
REQ-004 SHALL have parameter Y_MAX, default 300, launch Y and lower flight clamp.
REQ-005 SHALL have parameters STEP_LG_X, STEP_SM_X, STEP_LG_Y, STEP_SM_Y, defaults 8, 6, 5, 1, per-tick displacement magnitudes.
REQ-006 SHALL have parameters FLY_TICKS, HIT_TICKS, FALL_STEP, defaults 40, 5, 8: escape timeout, hit hold, fall speed.
REQ-007 SHALL have port ANIM_Clk, in, 1, animation tick clock.
REQ-008 SHALL have port Reset, in, 1, asynchronous active-high reset.
REQ-009 SHALL have port Start, in, 1, launch request.
REQ-010 SHALL have port Shot, in, 1, hit indication.
REQ-011 SHALL have port Color_in, in, 2, duck color: 0 black, 1 red, 2 pink, 3 treated as 0.
REQ-012 SHALL have port Dir_in, in, 2, direction: 0 NW, 1 W, 2 NE, 3 E.
REQ-013 SHALL have port Start_X, in, 10, launch X.
REQ-014 SHALL have ports Duck_X, Duck_Y, out, 10 each, sprite position.
REQ-015 SHALL have port DuckFrame, out, 6, sprite frame index.
REQ-016 SHALL have ports Busy, Done, Result, out, 1 each: in flight, 1-tick completion pulse, 1=shot/0=escaped.

Function
REQ-017 States SHALL be IDLE, LAUNCH, FLY, HIT, FALL, ESCAPE, DONE; all transitions occur on posedge ANIM_Clk.
REQ-018 IDLE: Start=1 SHALL capture color, direction, clamp(Start_X, X_MIN, X_MAX) and go to LAUNCH; Start outside IDLE is ignored.
REQ-019 LAUNCH: Duck_X=captured X, Duck_Y=Y_MAX, vertical sense=up, fly counter=0, Busy=1; next state FLY.
REQ-020 FLY per tick: NW x-=SM_X,y-=LG_Y; W x-=LG_X,y-=SM_Y; NE x+=SM_X,y-=LG_Y; E x+=LG_X,y-=SM_Y; y sign inverts when vertical sense=down.
REQ-021 Next-position arithmetic SHALL use 12-bit signed intermediates; no 10-bit underflow wrap permitted.
REQ-022 Horizontal bounce: next x<X_MIN or >X_MAX SHALL clamp x and swap NW<->NE, W<->E in the same tick.
REQ-023 Vertical bounce: next y<Y_MIN clamps to Y_MIN and sets sense=down; next y>Y_MAX clamps to Y_MAX and sets sense=up.
REQ-024 FLY frame SHALL be color*20 + dir offset (NE 0, E 4, NW 11, W 15) + phase, phase 0..3 incrementing per tick, wrapping 3->0, reset to 0 on direction change.
REQ-025 FLY: Shot=1 -> HIT; else fly counter reaching FLY_TICKS-1 -> ESCAPE; Shot and timeout on same tick -> HIT.
REQ-026 HIT: position frozen, frame color*20+8, held exactly HIT_TICKS ticks, then FALL.
REQ-027 FALL: y+=FALL_STEP per tick, x frozen, frame color*20+9; on y>=Y_MAX clamp to Y_MAX, Result=1, go DONE.
REQ-028 ESCAPE: y-=STEP_LG_Y per tick, x frozen, NW/NE frame by horizontal sense; on y<=Y_MIN clamp, Result=0, go DONE.
REQ-029 DONE: Done=1 for one tick, Busy=0, then IDLE; Result holds until next LAUNCH.
REQ-030 Shot outside FLY SHALL be ignored.

Reset
REQ-031 Reset SHALL force IDLE, Duck_X=0, Duck_Y=Y_MAX, DuckFrame=0, Busy=0, Done=0, Result=0, counters=0, sense=up.
REQ-032 Reset mid-flight SHALL abort without a Done pulse.

Structure
REQ-033 Package duck_pkg SHALL hold state enum, direction enum, color enum, frame-offset constants (20, 0, 4, 11, 15, 8, 9).
REQ-034 Combinational sub-module duck_frame_lut SHALL map (color, dir, mode, phase) to DuckFrame.

Verification
REQ-035 Start, color=1, Dir=E, X=400 -> LAUNCH (400,300) frame 24; then (408,299) 25, (416,298) 26, (424,297) 27, (432,296) 24.
REQ-036 Dir=E, X=600, X_MAX=607 -> first FLY tick x=607, dir W, frame 35; next tick x=599.
REQ-037 No Shot -> after 40 FLY ticks ESCAPE; y falls 5/tick to 0; Done 1 tick, Result=0.
REQ-038 Shot at FLY tick 3, color=0 -> 5 ticks frame 8, FALL frame 9 +8/tick to 300, Done, Result=1.
REQ-039 Shot on timeout tick -> HIT; Start during FLY ignored; Reset in FALL -> IDLE, Duck_Y=300, no Done.
